// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready flow control.
// SKID=1: registered in_ready, main entry plus one skid entry (full throughput,
//         no combinational path from out_ready to in_ready).
// SKID=0: single main entry, in_ready = !out_valid | out_ready.
// Flush empties the stage without touching out_data; rst clears everything.
// out_ctrl is gated by out_valid so a bubble never carries live control bits.
// stall_cnt saturates and is only cleared by rst.
//
// state   | meaning
// S_EMPTY | nothing held, out_valid low, in_ready high
// S_HALF  | one beat in main, presented downstream, in_ready high
// S_FULL  | main presented, second beat parked in skid, in_ready low
module pipe_stage_reg #(
   parameter int DATA_W = 133,
   parameter int CTRL_W = 9,
   parameter int CNT_W  = 16,
   parameter bit SKID   = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CTRL_W-1:0] in_ctrl,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [CTRL_W-1:0] out_ctrl,
   output logic [DATA_W-1:0] out_data,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_HALF  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [CTRL_W-1:0] main_ctrl;
   logic [DATA_W-1:0] main_data;
   logic              accept;

   assign accept   = in_valid & in_ready;
   assign out_ctrl = main_ctrl & {CTRL_W{out_valid}};
   assign out_data = main_data;

   generate
      if (SKID) begin : g_skid
         state_t            state;
         state_t            state_nxt;
         logic              ld_main_in;
         logic              ld_main_skid;
         logic              ld_skid;
         logic [CTRL_W-1:0] skid_ctrl;
         logic [DATA_W-1:0] skid_data;

         assign in_ready  = (state != S_FULL);
         assign out_valid = (state != S_EMPTY);

         // Next state and entry load enables; flush overrides any transfer.
         always_comb begin
            state_nxt    = state;
            ld_main_in   = 1'b0;
            ld_main_skid = 1'b0;
            ld_skid      = 1'b0;
            if (flush) begin
               state_nxt = S_EMPTY;
            end else begin
               case (state)
                  S_EMPTY: begin
                     if (accept) begin
                        ld_main_in = 1'b1;
                        state_nxt  = S_HALF;
                     end
                  end
                  S_HALF: begin
                     if (accept && out_ready) begin
                        ld_main_in = 1'b1;
                     end else if (accept) begin
                        ld_skid   = 1'b1;
                        state_nxt = S_FULL;
                     end else if (out_ready) begin
                        state_nxt = S_EMPTY;
                     end
                  end
                  S_FULL: begin
                     if (out_ready) begin
                        ld_main_skid = 1'b1;
                        state_nxt    = S_HALF;
                     end
                  end
                  default: state_nxt = S_EMPTY;
               endcase
            end
         end

         // State register plus main/skid entries.
         always_ff @(posedge clk) begin
            if (rst) begin
               state     <= S_EMPTY;
               main_ctrl <= '0;
               main_data <= '0;
               skid_ctrl <= '0;
               skid_data <= '0;
            end else begin
               state <= state_nxt;
               if (ld_main_in) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end else if (ld_main_skid) begin
                  main_ctrl <= skid_ctrl;
                  main_data <= skid_data;
               end
               if (ld_skid) begin
                  skid_ctrl <= in_ctrl;
                  skid_data <= in_data;
               end
            end
         end
      end else begin : g_single
         logic valid_q;
         logic valid_nxt;
         logic ld_main;

         assign out_valid = valid_q;
         assign in_ready  = !valid_q | out_ready;

         // Occupancy update: accept refills, a bare delivery empties, flush kills.
         always_comb begin
            valid_nxt = valid_q;
            ld_main   = 1'b0;
            if (flush) begin
               valid_nxt = 1'b0;
            end else if (accept) begin
               ld_main   = 1'b1;
               valid_nxt = 1'b1;
            end else if (out_ready) begin
               valid_nxt = 1'b0;
            end
         end

         // Valid flag and main entry.
         always_ff @(posedge clk) begin
            if (rst) begin
               valid_q   <= 1'b0;
               main_ctrl <= '0;
               main_data <= '0;
            end else begin
               valid_q <= valid_nxt;
               if (ld_main) begin
                  main_ctrl <= in_ctrl;
                  main_data <= in_data;
               end
            end
         end
      end
   endgenerate

   // Saturating count of cycles where a beat is presented but not taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (out_valid && !out_ready && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: DUT a is SKID=1 with a 4-bit stall counter,
// DUT b is SKID=0 with a 16-bit counter. "mode" selects which one receives
// in_valid; a negedge monitor scoreboards every delivery of the active DUT.
module tb_pipe_stage_reg;
   localparam int DATA_W = 133;
   localparam int CTRL_W = 9;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst, flush, in_valid, out_ready;
   logic [CTRL_W-1:0] in_ctrl;
   logic [DATA_W-1:0] in_data;
   int                mode;

   logic              in_valid_a, in_valid_b;
   logic              rdy_a, rdy_b, ov_a, ov_b;
   logic [CTRL_W-1:0] octl_a, octl_b;
   logic [DATA_W-1:0] odat_a, odat_b;
   logic [3:0]        cnt_a;
   logic [15:0]       cnt_b;

   logic              m_rdy, m_ov;
   logic [CTRL_W-1:0] m_octl;
   logic [DATA_W-1:0] m_odat;
   logic [15:0]       m_cnt;

   assign in_valid_a = in_valid & (mode == 0);
   assign in_valid_b = in_valid & (mode == 1);
   assign m_rdy  = (mode == 0) ? rdy_a  : rdy_b;
   assign m_ov   = (mode == 0) ? ov_a   : ov_b;
   assign m_octl = (mode == 0) ? octl_a : octl_b;
   assign m_odat = (mode == 0) ? odat_a : odat_b;
   assign m_cnt  = (mode == 0) ? {12'b0, cnt_a} : cnt_b;

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(4), .SKID(1'b1)) u_a (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid_a), .in_ready(rdy_a), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov_a), .out_ready(out_ready), .out_ctrl(octl_a), .out_data(odat_a),
      .stall_cnt(cnt_a));

   pipe_stage_reg #(.DATA_W(DATA_W), .CTRL_W(CTRL_W), .CNT_W(16), .SKID(1'b0)) u_b (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid_b), .in_ready(rdy_b), .in_ctrl(in_ctrl), .in_data(in_data),
      .out_valid(ov_b), .out_ready(out_ready), .out_ctrl(octl_b), .out_data(odat_b),
      .stall_cnt(cnt_b));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int n_hs = 0;
   int n_deliv = 0;
   logic [CTRL_W+DATA_W-1:0] sb[$];
   int deliv_cyc[$];
   logic prev_hold = 1'b0;
   logic [DATA_W-1:0] prev_data;
   logic [CTRL_W+DATA_W-1:0] exp_b;

   function automatic logic [DATA_W-1:0] beat_data(input int k);
      logic [31:0] w;
      w = 32'(k) * 32'h9E37_79B1;
      return {5'(k), w, ~w, w ^ 32'hA5A5_A5A5, 32'(k)};
   endfunction

   function automatic logic [CTRL_W-1:0] beat_ctrl(input int k);
      return CTRL_W'(k * 7 + 1);
   endfunction

   task automatic set_beat(input int k);
      in_ctrl = beat_ctrl(k);
      in_data = beat_data(k);
   endtask

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #2;
   endtask

   // Scoreboard and per-cycle invariants, sampled mid-cycle.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
         prev_hold = 1'b0;
      end else begin
         if (!m_ov) begin
            checks++;
            if (m_octl !== '0) begin failures++; $display("FAIL bubble_ctrl cyc=%0d got=%h want=0", cyc, m_octl); end
         end
         if (mode == 1) begin
            checks++;
            if (m_rdy !== (!m_ov | out_ready)) begin failures++; $display("FAIL single_in_ready cyc=%0d got=%b want=%b", cyc, m_rdy, !m_ov | out_ready); end
         end
         if (prev_hold) begin
            checks++;
            if (m_ov !== 1'b1 || m_odat !== prev_data) begin failures++; $display("FAIL stall_stable cyc=%0d valid=%b data=%h want_data=%h", cyc, m_ov, m_odat, prev_data); end
         end
         if (m_ov && out_ready) begin
            n_deliv++;
            deliv_cyc.push_back(cyc);
            checks++;
            if (sb.size() == 0) begin
               failures++; $display("FAIL unexpected_beat cyc=%0d got=%h want=none", cyc, m_odat);
            end else begin
               exp_b = sb.pop_front();
               if ({m_octl, m_odat} !== exp_b) begin failures++; $display("FAIL beat_order cyc=%0d got=%h want=%h", cyc, {m_octl, m_odat}, exp_b); end
            end
         end
         if (in_valid && m_rdy) n_hs++;
         if (flush) sb.delete();
         else if (in_valid && m_rdy) sb.push_back({in_ctrl, in_data});
         prev_hold = m_ov && !out_ready && !flush;
         prev_data = m_odat;
      end
      cyc++;
   end

   task automatic do_reset(input int m);
      mode = m; rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0;
      cycle(); cycle();
      rst = 1'b0;
      deliv_cyc.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; mode = 0;
      cycle(); cycle(); settle();
      checks++; if (ov_a !== 1'b0)   begin failures++; $display("FAIL rst_ov_a got=%b want=0", ov_a); end
      checks++; if (rdy_a !== 1'b1)  begin failures++; $display("FAIL rst_rdy_a got=%b want=1", rdy_a); end
      checks++; if (octl_a !== '0)   begin failures++; $display("FAIL rst_ctrl_a got=%h want=0", octl_a); end
      checks++; if (odat_a !== '0)   begin failures++; $display("FAIL rst_data_a got=%h want=0", odat_a); end
      checks++; if (cnt_a !== '0)    begin failures++; $display("FAIL rst_cnt_a got=%0d want=0", cnt_a); end
      checks++; if (ov_b !== 1'b0)   begin failures++; $display("FAIL rst_ov_b got=%b want=0", ov_b); end
      checks++; if (rdy_b !== 1'b1)  begin failures++; $display("FAIL rst_rdy_b got=%b want=1", rdy_b); end
      checks++; if (octl_b !== '0)   begin failures++; $display("FAIL rst_ctrl_b got=%h want=0", octl_b); end
      checks++; if (odat_b !== '0)   begin failures++; $display("FAIL rst_data_b got=%h want=0", odat_b); end
      checks++; if (cnt_b !== '0)    begin failures++; $display("FAIL rst_cnt_b got=%0d want=0", cnt_b); end
      cycle();
      rst = 1'b0;
   endtask

   task automatic test_streaming(input int m);
      int t0;
      do_reset(m);
      out_ready = 1'b1;
      t0 = cyc;
      for (int k = 1; k <= 8; k++) begin
         in_valid = 1'b1; set_beat(k); settle();
         checks++; if (m_rdy !== 1'b1) begin failures++; $display("FAIL stream_rdy m=%0d k=%0d got=%b want=1", m, k, m_rdy); end
         cycle();
      end
      in_valid = 1'b0;
      cycle(); cycle(); settle();
      checks++; if (deliv_cyc.size() != 8) begin failures++; $display("FAIL stream_count m=%0d got=%0d want=8", m, deliv_cyc.size()); end
      for (int i = 0; i < deliv_cyc.size() && i < 8; i++) begin
         checks++; if (deliv_cyc[i] != t0 + 1 + i) begin failures++; $display("FAIL stream_timing m=%0d i=%0d got=%0d want=%0d", m, i, deliv_cyc[i], t0 + 1 + i); end
      end
      checks++; if (m_cnt !== 16'd0) begin failures++; $display("FAIL stream_stall m=%0d got=%0d want=0", m, m_cnt); end
   endtask

   task automatic test_stall(input int m);
      int hs0, nb, tc4, id;
      bit [6:0] rdy_tab;
      bit [7:0] ov_tab;
      do_reset(m);
      rdy_tab = (m == 0) ? 7'b1100011 : 7'b1110001;
      ov_tab  = 8'b0111_1110;
      hs0 = n_hs;
      tc4 = 0;
      for (int c = 0; c < 8; c++) begin
         out_ready = (c >= 1 && c <= 3) ? 1'b0 : 1'b1;
         nb = n_hs - hs0;
         if (nb < 3) begin in_valid = 1'b1; set_beat(11 + nb); end
         else in_valid = 1'b0;
         settle();
         if (c == 4) tc4 = cyc;
         if (c <= 6) begin
            checks++; if (m_rdy !== rdy_tab[c]) begin failures++; $display("FAIL stall_rdy m=%0d c=%0d got=%b want=%b", m, c, m_rdy, rdy_tab[c]); end
         end
         checks++; if (m_ov !== ov_tab[c]) begin failures++; $display("FAIL stall_ov m=%0d c=%0d got=%b want=%b", m, c, m_ov, ov_tab[c]); end
         if (c >= 1 && c <= 6) begin
            id = (c <= 4) ? 11 : ((c == 5) ? 12 : 13);
            checks++; if (m_odat !== beat_data(id)) begin failures++; $display("FAIL stall_data m=%0d c=%0d got=%h want=%h", m, c, m_odat, beat_data(id)); end
         end
         cycle();
      end
      settle();
      checks++; if (m_cnt !== 16'd3) begin failures++; $display("FAIL stall_cnt m=%0d got=%0d want=3", m, m_cnt); end
      checks++; if (deliv_cyc.size() != 3) begin failures++; $display("FAIL stall_count m=%0d got=%0d want=3", m, deliv_cyc.size()); end
      for (int i = 0; i < deliv_cyc.size() && i < 3; i++) begin
         checks++; if (deliv_cyc[i] != tc4 + i) begin failures++; $display("FAIL stall_timing m=%0d i=%0d got=%0d want=%0d", m, i, deliv_cyc[i], tc4 + i); end
      end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL stall_left m=%0d got=%0d want=0", m, sb.size()); end
   endtask

   task automatic test_flush();
      int d0;
      do_reset(0);
      out_ready = 1'b1; in_valid = 1'b1; set_beat(21); cycle();
      out_ready = 1'b0; set_beat(22); settle();
      checks++; if (rdy_a !== 1'b1) begin failures++; $display("FAIL flush_half_rdy got=%b want=1", rdy_a); end
      cycle();
      flush = 1'b1; set_beat(23); settle();
      checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL flush_full_rdy got=%b want=0", rdy_a); end
      cycle();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; d0 = n_deliv; settle();
      checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL flush_ov got=%b want=0", ov_a); end
      checks++; if (octl_a !== '0) begin failures++; $display("FAIL flush_ctrl got=%h want=0", octl_a); end
      checks++; if (odat_a !== beat_data(21)) begin failures++; $display("FAIL flush_data_kept got=%h want=%h", odat_a, beat_data(21)); end
      cycle(); settle();
      checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL flush_stays_empty got=%b want=0", ov_a); end
      cycle();
      in_valid = 1'b1; set_beat(24); cycle();
      in_valid = 1'b0; settle();
      checks++; if (ov_a !== 1'b1 || odat_a !== beat_data(24)) begin failures++; $display("FAIL flush_next got=%b/%h want=1/%h", ov_a, odat_a, beat_data(24)); end
      cycle(); settle();
      checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL flush_next_alone got=%b want=0", ov_a); end
      checks++; if (n_deliv - d0 != 1) begin failures++; $display("FAIL flush_deliveries got=%0d want=1", n_deliv - d0); end
      for (int m = 0; m < 2; m++) begin
         do_reset(m);
         out_ready = 1'b1; in_valid = 1'b1; set_beat(25); cycle();
         d0 = n_deliv;
         flush = 1'b1; set_beat(26); cycle();
         flush = 1'b0; in_valid = 1'b0; settle();
         checks++; if (m_ov !== 1'b0) begin failures++; $display("FAIL flush_acc_ov m=%0d got=%b want=0", m, m_ov); end
         checks++; if (m_odat !== beat_data(25)) begin failures++; $display("FAIL flush_acc_data m=%0d got=%h want=%h", m, m_odat, beat_data(25)); end
         checks++; if (n_deliv - d0 != 1) begin failures++; $display("FAIL flush_acc_deliv m=%0d got=%0d want=1", m, n_deliv - d0); end
         cycle(); settle();
         checks++; if (m_ov !== 1'b0) begin failures++; $display("FAIL flush_acc_drop m=%0d got=%b want=0", m, m_ov); end
      end
   endtask

   task automatic test_bubble();
      for (int m = 0; m < 2; m++) begin
         do_reset(m);
         out_ready = 1'b1; in_valid = 1'b1; in_ctrl = 9'h1FF; in_data = beat_data(31);
         cycle();
         in_valid = 1'b0; settle();
         checks++; if (m_ov !== 1'b1 || m_octl !== 9'h1FF) begin failures++; $display("FAIL bubble_live m=%0d got=%b/%h want=1/1ff", m, m_ov, m_octl); end
         cycle(); settle();
         checks++; if (m_ov !== 1'b0 || m_octl !== '0) begin failures++; $display("FAIL bubble_gate m=%0d got=%b/%h want=0/0", m, m_ov, m_octl); end
         checks++; if (m_odat !== beat_data(31)) begin failures++; $display("FAIL bubble_data m=%0d got=%h want=%h", m, m_odat, beat_data(31)); end
      end
   endtask

   task automatic test_saturation();
      do_reset(0);
      out_ready = 1'b0; in_valid = 1'b1; set_beat(41); cycle();
      in_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         settle();
         if (i == 15) begin
            checks++; if (cnt_a !== 4'd14) begin failures++; $display("FAIL sat_below got=%0d want=14", cnt_a); end
         end
         cycle();
      end
      settle();
      checks++; if (cnt_a !== 4'd15) begin failures++; $display("FAIL sat_top got=%0d want=15", cnt_a); end
      flush = 1'b1; cycle();
      flush = 1'b0; settle();
      checks++; if (cnt_a !== 4'd15) begin failures++; $display("FAIL sat_flush got=%0d want=15", cnt_a); end
      checks++; if (ov_a !== 1'b0) begin failures++; $display("FAIL sat_flush_ov got=%b want=0", ov_a); end
      rst = 1'b1; cycle();
      rst = 1'b0; settle();
      checks++; if (cnt_a !== 4'd0) begin failures++; $display("FAIL sat_rst got=%0d want=0", cnt_a); end
   endtask

   task automatic test_reset_mid();
      int d0;
      do_reset(0);
      out_ready = 1'b1; in_valid = 1'b1; set_beat(51); cycle();
      out_ready = 1'b0; set_beat(52); cycle();
      settle();
      checks++; if (rdy_a !== 1'b0) begin failures++; $display("FAIL rmid_full got=%b want=0", rdy_a); end
      rst = 1'b1; flush = 1'b1; set_beat(53); cycle();
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; d0 = n_deliv; settle();
      checks++; if (ov_a !== 1'b0 || rdy_a !== 1'b1) begin failures++; $display("FAIL rmid_state got=%b/%b want=0/1", ov_a, rdy_a); end
      checks++; if (cnt_a !== 4'd0 || odat_a !== '0) begin failures++; $display("FAIL rmid_clear got=%0d/%h want=0/0", cnt_a, odat_a); end
      cycle();
      out_ready = 1'b1; in_valid = 1'b1; set_beat(54); cycle();
      in_valid = 1'b0; settle();
      checks++; if (ov_a !== 1'b1 || odat_a !== beat_data(54)) begin failures++; $display("FAIL rmid_next got=%b/%h want=1/%h", ov_a, odat_a, beat_data(54)); end
      cycle(); settle();
      checks++; if (n_deliv - d0 != 1) begin failures++; $display("FAIL rmid_deliv got=%0d want=1", n_deliv - d0); end
   endtask

   task automatic test_random(input int m);
      int hs0, d0, nb;
      do_reset(m);
      hs0 = n_hs; d0 = n_deliv;
      for (int t = 0; t < 600 && (n_deliv - d0) < 40; t++) begin
         nb = n_hs - hs0;
         if (nb < 40 && $urandom_range(0, 3) != 0) begin in_valid = 1'b1; set_beat(100 + nb); end
         else in_valid = 1'b0;
         out_ready = ($urandom_range(0, 2) != 0);
         cycle();
      end
      in_valid = 1'b0; settle();
      checks++; if (n_deliv - d0 != 40) begin failures++; $display("FAIL random_count m=%0d got=%0d want=40", m, n_deliv - d0); end
      checks++; if (sb.size() != 0) begin failures++; $display("FAIL random_left m=%0d got=%0d want=0", m, sb.size()); end
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_ctrl = '0; in_data = '0; mode = 0;
      test_reset();
      test_streaming(0);
      test_streaming(1);
      test_stall(0);
      test_stall(1);
      test_flush();
      test_bubble();
      test_saturation();
      test_reset_mid();
      test_random(0);
      test_random(1);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog time limit reached checks=%0d", checks);
      $fatal(1, "time limit");
   end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Generic parametrised pipeline stage register with valid/ready flow control, a two-entry skid buffer, synchronous flush and bubble control-gating. It replaces the fixed-field inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) between CPU pipeline stages. It adds stall back-pressure, which a plain register cannot hold, and keeps full throughput. It also counts stall cycles for performance debug.

## Interface
- DATA_W, 133, width of the datapath payload (e.g. result, PC, RD2, OR_PC, WN concatenated)
- CTRL_W, 9, width of the control bundle (regWrite, memRead, memWrite, branch, jump, jal, ...)
- CNT_W, 16, width of the stall counter
- SKID, 1, 1 = registered in_ready with a skid entry; 0 = single entry, in_ready combinational
- clk  in  1  clock
- rst  in  1  reset rst, synchronous, active-high
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream beat valid
- in_ready  out  1  stage can accept a beat this cycle
- in_ctrl  in  CTRL_W  upstream control bundle
- in_data  in  DATA_W  upstream payload
- out_valid  out  1  downstream beat valid
- out_ready  in  1  downstream accepts beat
- out_ctrl  out  CTRL_W  control bundle, forced to 0 when out_valid=0
- out_data  out  DATA_W  payload, holds its last value when invalid
- stall_cnt  out  CNT_W  saturating count of stalled cycles

## Operation
- Accept occurs when in_valid & in_ready. Delivery occurs when out_valid & out_ready.
- SKID=1 uses a state machine on the registered state {EMPTY, HALF, FULL}.
  - in_ready = (state != FULL), with no combinational path from out_ready.
  - out_valid = (state != EMPTY).
  - EMPTY: on accept, main <= in, go to HALF.
  - HALF, accept with out_ready: main <= in, stay in HALF.
  - HALF, accept without out_ready: skid <= in, go to FULL.
  - HALF, no accept with out_ready: go to EMPTY.
  - HALF, otherwise: hold.
  - FULL, out_ready: main <= skid, go to HALF.
  - FULL, no out_ready: hold.
- SKID=0 uses a single main register.
  - in_ready = !out_valid | out_ready.
  - On accept, main <= in and out_valid <= 1.
  - On a delivery without accept, out_valid <= 0.
- Ordering is strict FIFO. Beats are never duplicated or dropped, except on flush.
- out_ctrl = main_ctrl & {CTRL_W{out_valid}}. A bubble therefore never asserts regWrite or memWrite downstream.
- Flush:
  - The next state is EMPTY (out_valid=0) and the skid entry is invalidated.
  - Any beat accepted in the flush cycle is discarded.
  - The delivery in the flush cycle still counts as delivered. It is the downstream's responsibility to ignore it.
  - out_data is not cleared.
- stall_cnt increments by 1 each cycle with out_valid & !out_ready.
  - It saturates at 2^CNT_W-1.
  - It is cleared only by rst; flush does not clear it.
- Priority order: rst > flush > normal transfer.

## Timing
- Latency: a beat accepted at edge N appears on out_* after edge N (visible in cycle N+1).
- Throughput: one beat per cycle when out_ready is held at 1, in both modes.
- SKID=1: in_ready deasserts one cycle after the first stalled cycle in which a beat is accepted (HALF -> FULL). It reasserts the cycle after FULL drains.
- Reset values:
  - state=EMPTY, out_valid=0.
  - in_ready=1; in SKID=0 this follows from out_valid=0.
  - out_ctrl=0, out_data=0, stall_cnt=0.
  - Skid registers = 0.
- Reset asserted mid-stall (FULL) returns to EMPTY at the next edge and discards both entries.
- Simultaneous flush and rst: rst wins.
- Simultaneous flush and accept: the beat is discarded and the next state is EMPTY.
- out_valid/out_data remain stable while out_valid & !out_ready. This stability is asserted by the bench.

## Test plan
- Streaming: out_ready=1, 8 back-to-back beats with data 1..8 -> out_data 1..8 on consecutive cycles, one cycle of latency, stall_cnt=0.
- Stall and skid (SKID=1): beats A, B, C, with out_ready=0 for 3 cycles starting the cycle after A is accepted.
  - A is held on out_data.
  - B is accepted into skid and in_ready drops.
  - C waits upstream.
  - On release, A, B, C are delivered in order with no gap, and stall_cnt=3.
- Flush while FULL: state FULL holding A/B, flush=1 with in_valid=1 carrying C.
  - Next cycle: out_valid=0 and out_ctrl=0.
  - C is never delivered.
  - The next accepted beat D appears alone.
- Bubble gating: in_ctrl=9'h1FF is accepted and delivered, then in_valid=0.
  - out_ctrl = 9'h1FF for one cycle, then 0.
  - out_data keeps its last value.
- Saturation: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_cnt stops at 15. A flush leaves it at 15; rst clears it to 0.
- SKID=0 mode: repeat the streaming and stall scenarios.
  - in_ready equals !out_valid | out_ready every cycle.
  - No beat is lost.
  - Throughput is 1 beat/cycle when out_ready=1.
